// File: rtl/apb_master_bridge_pkg.sv
// Shared types and defaults for the APB master bridge: FSM state encoding,
// default geometry and the response record returned to the command side.
package apb_pkg;

    localparam int APB_ADDR_W     = 8;
    localparam int APB_DATA_W     = 32;
    localparam int APB_TIMEOUT    = 16;
    localparam int APB_MAX_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // rdata is sized for the widest legal bus; narrower builds use the low bits.
    typedef struct packed {
        logic [APB_MAX_DATA_W-1:0] rdata;
        logic                      err;
        logic                      timeout;
    } apb_rsp_t;

    function automatic int apb_strb_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Bundles the command/response handshake and the APB bus of the bridge.
// The master modport is the bridge's view; the slave modport is the far side.
interface apb_master_bridge_if
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_W,
    parameter int DATA_WIDTH = APB_DATA_W
);
    localparam int STRB_W = apb_strb_w(DATA_WIDTH);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [STRB_W-1:0]     cmd_strb;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    logic                  PSELx;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [STRB_W-1:0]     PSTRB;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_master_bridge_wait_timer.sv
// ACCESS wait-state counter: counts PREADY-low cycles and flags the cycle on
// which one more low cycle would reach the abort limit.
module apb_wait_timer
#(
    parameter int LIMIT = 16
)(
    input  logic PCLK,
    input  logic PRESETn,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [CW-1:0] r_count;
    logic          w_at_last;

    // Saturates at LIMIT so a stalled count can never wrap back into range.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != CW'(LIMIT))) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign w_at_last = (r_count == CW'(LIMIT - 1));
    assign o_expired = i_enable && w_at_last;

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB master: accepts one command, runs SETUP/ACCESS on
// the APB bus with a wait-state timeout, and holds the response until taken.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_W,
    parameter int DATA_WIDTH     = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT
)(
    input  logic                PCLK,
    input  logic                PRESETn,
    apb_master_bridge_if.master bus
);
    localparam int STRB_W = apb_strb_w(DATA_WIDTH);

    apb_state_e            r_state;
    apb_state_e            w_next;

    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [STRB_W-1:0]     r_pstrb;

    logic                  r_rsp_valid;
    apb_rsp_t              r_rsp;

    logic                  w_accept;
    logic                  w_done;
    logic                  w_abort;
    logic                  w_tmr_clear;
    logic                  w_tmr_enable;
    logic                  w_expired;

    apb_wait_timer #(
        .LIMIT     (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .i_clear   (w_tmr_clear),
        .i_enable  (w_tmr_enable),
        .o_expired (w_expired)
    );

    // The timer is cleared during SETUP so it starts from zero on ACCESS entry.
    assign w_tmr_clear  = (r_state == ST_SETUP);
    assign w_tmr_enable = (r_state == ST_ACCESS) && !bus.PREADY;

    assign w_accept = (r_state == ST_IDLE) && bus.cmd_valid;
    assign w_done   = (r_state == ST_ACCESS) && bus.PREADY;
    assign w_abort  = (r_state == ST_ACCESS) && !bus.PREADY && w_expired;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (bus.cmd_valid) w_next = ST_SETUP;
            ST_SETUP:  w_next = ST_ACCESS;
            ST_ACCESS: if (bus.PREADY || w_expired) w_next = ST_RESP;
            ST_RESP:   if (bus.rsp_ready) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Bus controls are registered from the next state so they change with it.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_psel      <= (w_next == ST_SETUP) || (w_next == ST_ACCESS);
            r_penable   <= (w_next == ST_ACCESS);
            r_rsp_valid <= (w_next == ST_RESP);
        end
    end

    // Address phase fields are latched at the handshake and held to the end.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
        end else if (w_accept) begin
            r_pwrite <= bus.cmd_write;
            r_paddr  <= bus.cmd_addr;
            r_pwdata <= bus.cmd_write ? bus.cmd_wdata : '0;
            r_pstrb  <= bus.cmd_write ? bus.cmd_strb  : '0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_rsp <= '0;
        end else if (w_done) begin
            r_rsp.rdata   <= r_pwrite ? '0 : APB_MAX_DATA_W'(bus.PRDATA);
            r_rsp.err     <= bus.PSLVERR;
            r_rsp.timeout <= 1'b0;
        end else if (w_abort) begin
            r_rsp.rdata   <= '0;
            r_rsp.err     <= 1'b1;
            r_rsp.timeout <= 1'b1;
        end
    end

    // cmd_ready is gated by the reset pin so it reads 0 throughout reset.
    assign bus.cmd_ready   = (r_state == ST_IDLE) && PRESETn;

    assign bus.PSELx       = r_psel;
    assign bus.PENABLE     = r_penable;
    assign bus.PWRITE      = r_pwrite;
    assign bus.PADDR       = r_paddr;
    assign bus.PWDATA      = r_pwdata;
    assign bus.PSTRB       = r_pstrb;

    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp.rdata[DATA_WIDTH-1:0];
    assign bus.rsp_err     = r_rsp.err;
    assign bus.rsp_timeout = r_rsp.timeout;

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 8, PADDR/cmd_addr width.
REQ-002 SHALL have parameter DATA_WIDTH, 32, PWDATA/PRDATA width; legal values are 8, 16 and 32.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, 16, maximum ACCESS wait cycles with PREADY low before abort; must be at least 1.
REQ-004 PCLK  in  1  single clock; all logic on rising edge.
REQ-005 PRESETn  in  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  in  1  request present.
REQ-007 cmd_ready  out  1  bridge can accept a request.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  ADDR_WIDTH  target address.
REQ-010 cmd_wdata  in  DATA_WIDTH  write data.
REQ-011 cmd_strb  in  DATA_WIDTH/8  write byte strobes.
REQ-012 rsp_valid  out  1  response present.
REQ-013 rsp_ready  in  1  response consumed.
REQ-014 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for aborted transfers.
REQ-015 rsp_err  out  1  PSLVERR or timeout.
REQ-016 rsp_timeout  out  1  transfer aborted by timeout.
REQ-017 PSELx, PENABLE, PWRITE  out  1 each  APB controls.
REQ-018 PADDR, PWDATA, PSTRB  out  ADDR_WIDTH, DATA_WIDTH, DATA_WIDTH/8  APB address, data and strobes.
REQ-019 PRDATA, PREADY, PSLVERR  in  DATA_WIDTH, 1, 1  APB slave responses.

Function
REQ-020 SHALL implement FSM states IDLE, SETUP, ACCESS and RESP; one transfer outstanding at a time.
REQ-021 cmd_ready SHALL be 1 only in IDLE; a handshake is cmd_valid&&cmd_ready at a rising edge, and it captures all cmd_* fields and moves the FSM to SETUP.
REQ-022 SETUP SHALL drive PSELx=1 and PENABLE=0 for exactly one cycle, then move to ACCESS.
REQ-023 ACCESS SHALL drive PSELx=1 and PENABLE=1 and stay in ACCESS until PREADY=1 is sampled or the timeout fires.
REQ-024 PADDR, PWRITE, PWDATA and PSTRB SHALL be registered and stable from SETUP through the last ACCESS cycle.
REQ-025 On reads the bridge SHALL drive PSTRB=0 and PWDATA=0.
REQ-026 PREADY=1 in ACCESS SHALL make the bridge capture PRDATA (reads only) and PSLVERR into rsp_*, set rsp_timeout=0, and move to RESP.
REQ-027 A wait counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with PREADY=0.
REQ-028 When the wait counter reaches TIMEOUT_CYCLES, the bridge SHALL move to RESP with rsp_err=1, rsp_timeout=1 and rsp_rdata=0.
REQ-029 PREADY=1 on the cycle the counter reaches TIMEOUT_CYCLES SHALL count as completion, not timeout.
REQ-030 RESP SHALL drive PSELx=0, PENABLE=0 and rsp_valid=1, holding rsp_* stable until rsp_ready=1 is sampled; the FSM then returns to IDLE.
REQ-031 Latency SHALL be: handshake at edge k; SETUP in cycle k+1; first ACCESS in cycle k+2; with zero wait states rsp_valid=1 in cycle k+3.
REQ-032 The next request SHALL NOT be accepted before the cycle after the rsp handshake, so PSELx has at least one idle cycle between transfers.
REQ-033 PREADY, PSLVERR and PRDATA SHALL be ignored outside ACCESS.
REQ-034 All APB outputs and rsp_* outputs SHALL be registered.

Reset
REQ-035 PRESETn=0 SHALL force IDLE asynchronously, with PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, rsp_rdata, rsp_err, rsp_timeout and the wait counter all 0.
REQ-036 cmd_ready SHALL be 0 while PRESETn=0 and 1 in the first cycle after deassertion.
REQ-037 Reset during SETUP, ACCESS or RESP SHALL abandon the transfer with no response issued.

Structure
REQ-038 Package apb_pkg SHALL hold the state enum, default ADDR_WIDTH/DATA_WIDTH/TIMEOUT_CYCLES constants and a response struct {rdata, err, timeout}.
REQ-039 The wait counter SHALL be a sub-module apb_wait_timer (clear, enable, expired); all other logic stays in one module.

Verification
REQ-040 Write, addr 0x10, data 0xDEADBEEF, strb 0xF, PREADY tied 1 -> one SETUP cycle then one ACCESS cycle with the same PADDR; rsp_valid in cycle k+3 with err=0, rdata=0.
REQ-041 Read of 0x24 with 3 PREADY-low wait cycles, PRDATA=0x12345678 -> ACCESS lasts 4 cycles; rsp_rdata=0x12345678, err=0.
REQ-042 Read with PSLVERR=1 together with PREADY -> rsp_err=1, rsp_timeout=0.
REQ-043 PREADY held 0 with TIMEOUT_CYCLES=16 -> exactly 16 ACCESS cycles, then rsp_err=1, rsp_timeout=1, PSELx=0.
REQ-044 rsp_ready held 0 for 5 cycles while cmd_valid stays 1 -> rsp_* stable, cmd_ready=0, no PSELx activity until the rsp handshake.
REQ-045 PRESETn pulled low mid-ACCESS -> PSELx and PENABLE go 0 immediately, no rsp_valid, and cmd_ready=1 after release.
